// File: rtl/dct_pkg.sv
// Shared definitions for the single-coefficient 2D DCT engine: FSM encoding,
// default geometry and the elaboration-time cosine table generator.
package dct_pkg;

  localparam int DCT_N_DEFAULT    = 8;
  localparam int DCT_FRAC_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

  // round(2^frac * cos((2n+1)k*pi/(2nn))); only evaluated at elaboration time
  function automatic int cos_rom_value(input int k, input int n, input int nn, input int frac);
    real ang;
    real scaled;
    ang    = (2.0 * real'(n) + 1.0) * real'(k) * 3.14159265358979323846 / (2.0 * real'(nn));
    scaled = $cos(ang) * (2.0 ** real'(frac));
    return $rtoi($floor(scaled + 0.5));
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// N x N one-dimensional DCT cosine table with two independent combinational
// read ports, one for the row frequency and one for the column frequency.
module dct_cos_rom
  import dct_pkg::*;
#(
  parameter int N    = DCT_N_DEFAULT,
  parameter int FRAC = DCT_FRAC_DEFAULT
) (
  input  logic [$clog2(N)-1:0] k1,
  input  logic [$clog2(N)-1:0] n1,
  input  logic [$clog2(N)-1:0] k2,
  input  logic [$clog2(N)-1:0] n2,
  output logic signed [FRAC+1:0] c1,
  output logic signed [FRAC+1:0] c2
);

  logic signed [FRAC+1:0] rom_mem [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_freq
    for (genvar gj = 0; gj < N; gj++) begin : g_sample
      localparam int CV = cos_rom_value(gi, gj, N, FRAC);
      assign rom_mem[gi][gj] = (FRAC+2)'(CV);
    end
  end

  assign c1 = rom_mem[k1][n1];
  assign c2 = rom_mem[k2][n2];

endmodule

// File: rtl/dct_coef_engine.sv
// Computes one unscaled 2D DCT coefficient X[k1][k2] over a streamed N x N
// pixel block: registered product stage, wide accumulator, saturating output.
module dct_coef_engine
  import dct_pkg::*;
#(
  parameter int N    = DCT_N_DEFAULT,
  parameter int DW   = 9,
  parameter int FRAC = DCT_FRAC_DEFAULT,
  parameter int OW   = 16,
  parameter int AW   = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [$clog2(N)-1:0]    cfg_k1,
  input  logic [$clog2(N)-1:0]    cfg_k2,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OW-1:0]    out_coef,
  output logic                    busy
);

  localparam int KW   = $clog2(N);
  localparam int CNTW = 2 * KW;
  localparam int CW   = 2 * FRAC + 4;
  localparam logic [CNTW-1:0] CNT_LAST = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic signed [AW-1:0] OUT_MAX = AW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] OUT_MIN = ~OUT_MAX;

  dct_state_e              state_reg, state_next;
  logic [KW-1:0]           k1_reg, k2_reg;
  logic [CNTW-1:0]         cnt_reg;
  logic signed [AW-1:0]    prod_reg, prod_next;
  logic                    prod_valid_reg;
  logic signed [AW-1:0]    acc_reg;
  logic                    out_valid_reg;
  logic signed [OW-1:0]    out_coef_reg;

  logic                    accept;
  logic signed [FRAC+1:0]  c1, c2;
  logic signed [CW-1:0]    cc_full, term_wide;
  logic signed [AW-1:0]    pix_ext, term_ext;
  logic signed [AW-1:0]    acc_shift;
  logic signed [OW-1:0]    coef_sat;

  dct_cos_rom #(
    .N    (N),
    .FRAC (FRAC)
  ) u_rom (
    .k1 (k1_reg),
    .n1 (cnt_reg[CNTW-1:KW]),
    .k2 (k2_reg),
    .n2 (cnt_reg[KW-1:0]),
    .c1 (c1),
    .c2 (c2)
  );

  assign accept    = (state_reg == ST_ACCUM) && in_valid;
  assign cc_full   = CW'(c1) * CW'(c2);
  assign term_wide = cc_full >>> FRAC;
  assign pix_ext   = AW'(in_pixel);
  assign term_ext  = AW'(term_wide);
  assign prod_next = pix_ext * term_ext;
  assign acc_shift = acc_reg >>> FRAC;

  always_comb begin
    coef_sat = acc_shift[OW-1:0];
    if (acc_shift > OUT_MAX) begin
      coef_sat = OUT_MAX[OW-1:0];
    end else if (acc_shift < OUT_MIN) begin
      coef_sat = OUT_MIN[OW-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ACCUM;
      ST_ACCUM: if (accept && (cnt_reg == CNT_LAST)) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE:  if (out_valid_reg && out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      k1_reg         <= '0;
      k2_reg         <= '0;
      cnt_reg        <= '0;
      prod_reg       <= '0;
      prod_valid_reg <= 1'b0;
      acc_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_coef_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) && start) begin
        k1_reg         <= cfg_k1;
        k2_reg         <= cfg_k2;
        cnt_reg        <= '0;
        prod_valid_reg <= 1'b0;
        acc_reg        <= '0;
      end else begin
        prod_valid_reg <= accept;
        if (accept) begin
          prod_reg <= prod_next;
          // wraps to zero after the last pixel because N*N is a power of two
          cnt_reg  <= cnt_reg + CNT_ONE;
        end
        if (prod_valid_reg) begin
          acc_reg <= acc_reg + prod_reg;
        end
      end
      // the final product lands during FLUSH, so the result is captured one cycle into DONE
      if ((state_reg == ST_DONE) && !out_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_coef_reg  <= coef_sat;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_reg == ST_ACCUM);
  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = out_valid_reg;
  assign out_coef  = out_coef_reg;

endmodule

// File: doc/dct_coef_engine.md
DCT_COEF_ENGINE -- requirements
Module: dct_coef_engine

Interface
REQ-001 SHALL have parameter N, default 8: block edge; power of two, 4..16.
REQ-002 SHALL have parameter DW, default 9: signed pixel width (level-shifted).
REQ-003 SHALL have parameter FRAC, default 8: cosine fraction bits.
REQ-004 SHALL have parameter OW, default 16: signed output coefficient width.
REQ-005 SHALL have parameter AW, default 40: signed accumulator width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  begin a frame; sampled in IDLE only.
REQ-009 SHALL have port cfg_k1  input  $clog2(N)  row frequency index, latched on start.
REQ-010 SHALL have port cfg_k2  input  $clog2(N)  column frequency index, latched on start.
REQ-011 SHALL have port in_valid  input  1  pixel valid.
REQ-012 SHALL have port in_ready  output  1  pixel accepted when in_valid&&in_ready.
REQ-013 SHALL have port in_pixel  input  DW  signed pixel, row-major (n1 outer, n2 inner).
REQ-014 SHALL have port out_valid  output  1  coefficient valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts coefficient.
REQ-016 SHALL have port out_coef  output  OW  signed unscaled coefficient X[k1][k2].
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL use a 1D ROM c[k][n] = round(2^FRAC * cos((2n+1)k*pi/(2N))), signed FRAC+2 bits.
REQ-019 SHALL form term = (c[k1][n1]*c[k2][n2]) >>> FRAC (arithmetic), per accepted pixel.
REQ-020 SHALL accumulate in_pixel*term into an AW-bit signed accumulator, no internal wrap for legal parameters.
REQ-021 SHALL implement states IDLE, ACCUM, FLUSH, DONE.
REQ-022 IDLE->ACCUM on start: latch cfg_k1/cfg_k2, clear accumulator and pixel counter.
REQ-023 in_ready SHALL be high only in ACCUM; in_valid outside ACCUM is ignored.
REQ-024 Pixel counter SHALL count accepted pixels 0..N*N-1; n1 = count/N, n2 = count%N.
REQ-025 Product stage SHALL be registered: pixel accepted at edge E contributes to accumulator at edge E+1.
REQ-026 ACCUM->FLUSH on acceptance of pixel N*N-1; counter returns to 0; FLUSH lasts exactly one cycle.
REQ-027 FLUSH->DONE; out_valid SHALL rise at edge E+2 after last-pixel edge E.
REQ-028 out_coef SHALL be accumulator >>> FRAC, saturated to [-2^(OW-1), 2^(OW-1)-1].
REQ-029 out_valid/out_coef SHALL hold stable while out_valid&&!out_ready.
REQ-030 DONE->IDLE on out_valid&&out_ready; start in that cycle is ignored (sampled next cycle).
REQ-031 start asserted outside IDLE SHALL be ignored; cfg changes outside IDLE SHALL have no effect.
REQ-032 in_valid gaps in ACCUM SHALL stall counter and accumulator without corrupting the sum.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, in_ready=0, out_valid=0, out_coef=0, busy=0, counter=0, accumulator=0, product register=0, latched k1/k2=0.
REQ-034 Reset mid-frame SHALL discard the partial sum; no output is produced for that frame.
REQ-035 Deassertion SHALL be synchronised externally; block leaves IDLE only on a subsequent start.

Structure
REQ-036 Package dct_pkg SHALL hold the state enum, default N/FRAC, and a cosine-ROM generator function.
REQ-037 Sub-module dct_cos_rom SHALL hold the N x N 1D table, two read ports (k1,n1) and (k2,n2), combinational.
REQ-038 Core SHALL contain the FSM, counter, product register, accumulator and saturating output stage.

Verification (N=8, FRAC=8, DW=9)
REQ-039 k1=k2=0, 64 pixels of value 1, out_ready=1 -> out_coef=64, out_valid rises 2 edges after last accept.
REQ-040 k1=0,k2=1, 64 pixels of value 5 -> out_coef=0 (antisymmetric cosine cancels).
REQ-041 OW=12, k1=k2=0, 64 pixels of 127 -> unsaturated 8128 clamps to 2047; all -128 -> -2048.
REQ-042 Random in_valid gaps, random pixels, all 64 (k1,k2) pairs -> out_coef matches bit-exact model of REQ-018..028.
REQ-043 out_ready low 5 cycles in DONE -> out_coef, out_valid stable; start pulses ignored; IDLE after handshake.
REQ-044 rst_n low after 20 pixels -> all outputs 0 immediately; next full frame k1=k2=0 of 1s -> 64.
